// File: rtl/dmem_req_issuer_pkg.sv
// Shared definitions for the data-memory request issuer: access-op and bus-size
// encodings, default outstanding depth, and the per-transaction response tag.
package dmem_req_issuer_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'h0,
    OP_LBU = 4'h1,
    OP_LH  = 4'h2,
    OP_LHU = 4'h3,
    OP_LW  = 4'h4,
    OP_LWL = 4'h5,
    OP_LWR = 4'h6,
    OP_SB  = 4'h8,
    OP_SH  = 4'h9,
    OP_SW  = 4'hA,
    OP_SWL = 4'hB,
    OP_SWR = 4'hC
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  localparam int unsigned MAX_OUT_DEF = 2;
  localparam int unsigned CNT_W_DEF   = 2;

  typedef struct packed {
    logic wr;
    logic discard;
  } tag_t;

  // Bus size for a partial-word store covering nbytes contiguous lanes.
  function automatic logic [1:0] size_for_bytes(input logic [2:0] nbytes);
    logic [1:0] sz;
    case (nbytes)
      3'd1:    sz = SZ_BYTE;
      3'd2:    sz = SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/dmem_store_align.sv
// Combinational request encoder: op + address + rt -> bus size, byte strobes,
// lane-shifted write data and bus address. Store-side twin of the load merger.
module dmem_store_align
  import dmem_req_issuer_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] rt,
  output logic        wr,
  output logic [1:0]  size,
  output logic [3:0]  strb,
  output logic [31:0] wdata,
  output logic [31:0] bus_addr
);

  logic [1:0] a;
  logic [4:0] shl_amt;
  logic [4:0] shr_amt;

  assign a       = addr[1:0];
  assign shl_amt = {a, 3'b000};
  assign shr_amt = {~a, 3'b000};

  always_comb begin
    wr       = 1'b0;
    size     = SZ_WORD;
    strb     = 4'b0000;
    wdata    = 32'h0;
    bus_addr = addr;
    case (op)
      OP_LB, OP_LBU: size = SZ_BYTE;
      OP_LH, OP_LHU: size = SZ_HALF;
      OP_LW:         size = SZ_WORD;
      // unaligned word loads fetch the whole containing word
      OP_LWL, OP_LWR: bus_addr = {addr[31:2], 2'b00};
      OP_SB: begin
        wr    = 1'b1;
        size  = SZ_BYTE;
        strb  = 4'b0001 << a;
        wdata = {4{rt[7:0]}};
      end
      OP_SH: begin
        wr    = 1'b1;
        size  = SZ_HALF;
        strb  = a[1] ? 4'b1100 : 4'b0011;
        wdata = {2{rt[15:0]}};
      end
      OP_SW: begin
        wr    = 1'b1;
        strb  = 4'b1111;
        wdata = rt;
      end
      OP_SWL: begin
        wr    = 1'b1;
        strb  = 4'b1111 >> (~a);
        size  = size_for_bytes({1'b0, a} + 3'd1);
        wdata = rt >> shr_amt;
      end
      OP_SWR: begin
        wr    = 1'b1;
        strb  = 4'b1111 << a;
        size  = size_for_bytes(3'd4 - {1'b0, a});
        wdata = rt << shl_amt;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_req_issuer.sv
// Data-memory request issuer: accepts one access per handshake, drives the
// SRAM-like bus, and returns in-order responses, dropping flushed ones.
//   state  | meaning
//   S_IDLE | no request on the bus; may accept if an outstanding slot is free
//   S_REQ  | request registered and held on the bus until addr_ok
module dmem_req_issuer
  import dmem_req_issuer_pkg::*;
#(
  parameter int unsigned MAX_OUT = MAX_OUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_cancel,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        rsp_valid,
  output logic        rsp_wr,
  output logic [31:0] rsp_rdata
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        discard_q, discard_d;

  logic [CNT_W-1:0] out_q, out_d;
  tag_t             tag_q [MAX_OUT];
  tag_t             tag_d [MAX_OUT];

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_wr_q, rsp_wr_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        al_wr;
  logic [1:0]  al_size;
  logic [3:0]  al_strb;
  logic [31:0] al_wdata;
  logic [31:0] al_addr;

  logic             accept;
  logic             addr_hs;
  logic             pop;
  logic             head_discard;
  logic [CNT_W-1:0] push_idx;

  dmem_store_align u_align (
    .op       (in_op),
    .addr     (in_addr),
    .rt       (in_wdata),
    .wr       (al_wr),
    .size     (al_size),
    .strb     (al_strb),
    .wdata    (al_wdata),
    .bus_addr (al_addr)
  );

  assign in_ready     = (state_q == S_IDLE) && (out_q < CNT_W'(MAX_OUT));
  assign accept       = in_valid && in_ready && !in_cancel;
  assign addr_hs      = (state_q == S_REQ) && data_addr_ok;
  // a data_ok with nothing outstanding is a protocol error and is ignored
  assign pop          = data_data_ok && (out_q != '0);
  assign head_discard = tag_q[0].discard || in_cancel;
  assign push_idx     = out_q - CNT_W'(pop);

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    strb_d    = strb_q;
    wdata_d   = wdata_q;
    discard_d = discard_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_REQ;
          wr_d      = al_wr;
          size_d    = al_size;
          addr_d    = al_addr;
          strb_d    = al_strb;
          wdata_d   = al_wdata;
          discard_d = 1'b0;
        end
      end
      S_REQ: begin
        // the bus must still see the request through; only its response is dropped
        if (in_cancel) discard_d = 1'b1;
        if (data_addr_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_d = out_q + CNT_W'(addr_hs) - CNT_W'(pop);
    for (int i = 0; i < int'(MAX_OUT); i++) tag_d[i] = tag_q[i];
    if (pop) begin
      for (int i = 0; i < int'(MAX_OUT) - 1; i++) tag_d[i] = tag_q[i + 1];
      tag_d[MAX_OUT-1] = '0;
    end
    if (in_cancel) begin
      for (int i = 0; i < int'(MAX_OUT); i++) tag_d[i].discard = 1'b1;
    end
    if (addr_hs) begin
      for (int i = 0; i < int'(MAX_OUT); i++) begin
        if (CNT_W'(i) == push_idx) begin
          tag_d[i].wr      = wr_q;
          tag_d[i].discard = discard_q || in_cancel;
        end
      end
    end
  end

  always_comb begin
    rsp_valid_d = 1'b0;
    rsp_wr_d    = rsp_wr_q;
    rsp_rdata_d = rsp_rdata_q;
    if (pop && !head_discard) begin
      rsp_valid_d = 1'b1;
      rsp_wr_d    = tag_q[0].wr;
      rsp_rdata_d = data_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      size_q      <= 2'd0;
      addr_q      <= 32'h0;
      strb_q      <= 4'h0;
      wdata_q     <= 32'h0;
      discard_q   <= 1'b0;
      out_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_rdata_q <= 32'h0;
      for (int i = 0; i < int'(MAX_OUT); i++) tag_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      strb_q      <= strb_d;
      wdata_q     <= wdata_d;
      discard_q   <= discard_d;
      out_q       <= out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_rdata_q <= rsp_rdata_d;
      for (int i = 0; i < int'(MAX_OUT); i++) tag_q[i] <= tag_d[i];
    end
  end

  assign data_req   = (state_q == S_REQ);
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wstrb = strb_q;
  assign data_wdata = wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_wr     = rsp_wr_q;
  assign rsp_rdata  = rsp_rdata_q;

endmodule
